spi_sram_slave: RTL and testbench
=================================

Name: spi_sram_slave

Overview:
- Synthesizable SPI SRAM target (23LC1024-style command set, SPI mode 0). It is the responder end of the SPI SRAM link.
- SCLK, CS_n and MOSI are oversampled in the system clock domain. The block decodes read, fast-read and write commands and drives a simple synchronous byte-wide memory port.
- Used as an on-chip SRAM stand-in behind the SPI pins, and as a loopback target for the SPI SRAM master in system simulation.

Parameters:
- ADDR_W, 24, memory port address width; address bits above ADDR_W received on SPI are ignored.
- SYNC_STAGES, 2, synchronizer flops on spi_sclk/spi_cs_n/spi_mosi (min 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active low
- spi_sclk  input  1  SPI clock from master, asynchronous to clk
- spi_cs_n  input  1  chip select, active low
- spi_mosi  input  1  serial data in
- spi_miso  output  1  serial data out
- spi_miso_oe  output  1  output enable for spi_miso pad
- mem_addr  output  ADDR_W  byte address
- mem_en  output  1  one-cycle access strobe
- mem_wr  output  1  1 = write, 0 = read (qualified by mem_en)
- mem_wdata  output  8  write data
- mem_rdata  input  8  read data, valid exactly one clk after mem_en && !mem_wr
- active  output  1  high while a transaction is selected (cs_n low after sync)
- cmd_err  output  1  one-cycle pulse when an unsupported command byte completes

Behaviour:
Reset and timing assumptions
- Reset (rst_n low at a clk edge): state=IDLE; spi_miso=0, spi_miso_oe=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, active=0, cmd_err=0; synchronizer flops are preset to sclk=0, cs_n=1.
- Timing requirement: sclk high and low phases are each >= SYNC_STAGES+2 clk periods. CS_n setup/hold to sclk is >= the same. Faster sclk is unsupported and is not checked.
- Edge detect: rise/fall is derived from the synchronized sclk vs. its previous value. Events act SYNC_STAGES+1 clks after the pin edge.
- Mode 0: MOSI is sampled on sclk rise; MISO changes on sclk fall. MSB first.

Chip select and state machine
- Synchronized cs_n high forces IDLE from any state, clears the bit counter, sets spi_miso_oe=0, and discards any partial byte (no mem write). This holds even mid-byte and mid-prefetch; an outstanding mem_rdata is dropped.
- States: IDLE, CMD, ADDR, DUMMY, WRITE, READ, IGNORE.
- IDLE -> CMD on cs_n falling.
- CMD: shift 8 bits. On the 8th rise:
  - 0x02 or 0x03 -> ADDR.
  - 0x0B -> ADDR with dummy flag set.
  - Any other value -> pulse cmd_err, go to IGNORE (stay there until cs_n high; miso_oe=0).
- ADDR: shift 24 bits into addr. On the 24th rise:
  - Write -> WRITE.
  - Read without dummy -> issue mem_en with mem_wr=0 on the same clk, go to READ.
  - Read with dummy -> DUMMY.
- DUMMY: 8 rises ignored. On the 8th rise, issue the read, go to READ.

Read path
- READ: the shift register loads mem_rdata one clk after the read issue. spi_miso_oe=1 from the first sclk fall in READ.
- On each fall, spi_miso=shift[7] and the register shifts.
- On the 8th fall of each byte, addr increments and the next read is issued. The loaded byte is presented on the following fall, giving a continuous burst.

Write path
- WRITE: on each 8th rise, one clk pulse of mem_en=1, mem_wr=1, mem_addr=addr, mem_wdata=assembled byte. addr increments on the next clk.

Address and memory port rules
- Address increment wraps modulo 2^ADDR_W (all-ones -> 0).
- mem_en is never high on two consecutive clks. mem_addr and mem_wdata hold their value when mem_en=0.
- active = synchronized !cs_n.

Test Plan:
1. Write 0x02, addr 0x000010, data 0xA5 0x5A, then cs_n high -> two mem writes: (0x10,0xA5), (0x11,0x5A), no other mem_en.
2. Read 0x03, addr 0x000010, 16 data clocks with memory returning 0xA5@0x10 and 0x5A@0x11 -> MISO bytes 0xA5, 0x5A; reads issued at 0x10, 0x11, 0x12; miso_oe=0 during cmd/addr.
3. Fast read 0x0B, addr 0x000020, 8 dummy clocks, 8 data clocks, memory 0x3C@0x20 -> MISO=0x3C. First mem_en only after the 8th dummy rise.
4. Write starting at addr 0xFFFFFF, bytes 0x11 0x22 -> writes at 0xFFFFFF then 0x000000.
5. Command 0x9F -> cmd_err pulses once, no mem_en, miso_oe stays 0. Then a cs_n high/low cycle followed by 0x03 works normally.
6. Write 0x02, addr 0x40, 5 data bits then cs_n high -> no mem write. rst_n low mid-read -> all outputs return to reset values at the next clk.

Source files
------------

// File: rtl/spi_sram_slave_if.sv
// Pin-side SPI signals and byte-wide synchronous memory port of the SPI SRAM target.
// The slave modport is the target; the master modport is the SPI master plus the memory.
interface spi_sram_slave_if #(
   parameter int unsigned ADDR_W = 24
);
   logic              spi_sclk;
   logic              spi_cs_n;
   logic              spi_mosi;
   logic              spi_miso;
   logic              spi_miso_oe;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_en;
   logic              mem_wr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi, mem_rdata,
      output spi_miso, spi_miso_oe, mem_addr, mem_en, mem_wr, mem_wdata
   );

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi, mem_rdata,
      input  spi_miso, spi_miso_oe, mem_addr, mem_en, mem_wr, mem_wdata
   );
endinterface

// File: rtl/spi_sram_slave.sv
// SPI mode-0 SRAM target (read 0x03, fast read 0x0B, write 0x02) with oversampled pins
// driving a single-strobe synchronous byte memory port.
module spi_sram_slave #(
   parameter int unsigned ADDR_W      = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_sram_slave_if.slave bus,
   output logic            active,
   output logic            cmd_err
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WRITE, READ, IGNORE} state_t;

   localparam int unsigned CNT_W      = 5;
   localparam int unsigned SPI_ADDR_W = 24;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_prev;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   rise;
   logic                   fall;

   state_t                  state;
   logic [CNT_W-1:0]        bit_cnt;
   logic [6:0]              rx_sh;
   logic [7:0]              tx_sh;
   logic [SPI_ADDR_W-2:0]   addr_sh;
   logic [ADDR_W-1:0]       addr;
   logic                    is_wr;
   logic                    is_dummy;
   logic                    rd_wait;
   logic                    miso_q;
   logic                    miso_oe_q;
   logic [ADDR_W-1:0]       mem_addr_q;
   logic                    mem_en_q;
   logic                    mem_wr_q;
   logic [7:0]              mem_wdata_q;

   logic [7:0]              rx_byte;
   logic [SPI_ADDR_W-1:0]   addr_full;
   logic [ADDR_W-1:0]       addr_inc;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign rise      = sclk_s & ~sclk_prev;
   assign fall      = ~sclk_s & sclk_prev;
   assign rx_byte   = {rx_sh, mosi_s};
   assign addr_full = {addr_sh, mosi_s};
   assign addr_inc  = addr + ADDR_W'(1);

   assign bus.spi_miso    = miso_q;
   assign bus.spi_miso_oe = miso_oe_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_en      = mem_en_q;
   assign bus.mem_wr      = mem_wr_q;
   assign bus.mem_wdata   = mem_wdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync   <= '0;
         cs_sync     <= '1;
         mosi_sync   <= '0;
         sclk_prev   <= 1'b0;
         state       <= IDLE;
         bit_cnt     <= '0;
         rx_sh       <= '0;
         tx_sh       <= '0;
         addr_sh     <= '0;
         addr        <= '0;
         is_wr       <= 1'b0;
         is_dummy    <= 1'b0;
         rd_wait     <= 1'b0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= '0;
         active      <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
         sclk_prev <= sclk_s;
         active    <= ~cs_s;
         mem_en_q  <= 1'b0;
         cmd_err   <= 1'b0;
         // read data lands one clk after the memory sampled the strobe
         rd_wait   <= mem_en_q & ~mem_wr_q;
         if (rd_wait) tx_sh <= bus.mem_rdata;

         if (cs_s) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            miso_oe_q <= 1'b0;
            rd_wait   <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  state   <= CMD;
                  bit_cnt <= '0;
               end
               CMD: if (rise) begin
                  rx_sh   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(7)) begin
                     bit_cnt <= '0;
                     unique case (rx_byte)
                        8'h02: begin state <= ADDR; is_wr <= 1'b1; is_dummy <= 1'b0; end
                        8'h03: begin state <= ADDR; is_wr <= 1'b0; is_dummy <= 1'b0; end
                        8'h0B: begin state <= ADDR; is_wr <= 1'b0; is_dummy <= 1'b1; end
                        default: begin state <= IGNORE; cmd_err <= 1'b1; end
                     endcase
                  end
               end
               ADDR: if (rise) begin
                  addr_sh <= addr_full[SPI_ADDR_W-2:0];
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(SPI_ADDR_W - 1)) begin
                     bit_cnt <= '0;
                     addr    <= ADDR_W'(addr_full);
                     if (is_wr) begin
                        state <= WRITE;
                     end else if (is_dummy) begin
                        state <= DUMMY;
                     end else begin
                        state      <= READ;
                        mem_en_q   <= 1'b1;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= ADDR_W'(addr_full);
                     end
                  end
               end
               DUMMY: if (rise) begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(7)) begin
                     bit_cnt    <= '0;
                     state      <= READ;
                     mem_en_q   <= 1'b1;
                     mem_wr_q   <= 1'b0;
                     mem_addr_q <= addr;
                  end
               end
               WRITE: if (rise) begin
                  rx_sh   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(7)) begin
                     bit_cnt     <= '0;
                     mem_en_q    <= 1'b1;
                     mem_wr_q    <= 1'b1;
                     mem_addr_q  <= addr;
                     mem_wdata_q <= rx_byte;
                     addr        <= addr_inc;
                  end
               end
               READ: if (fall) begin
                  // bit 0 goes out on the 8th fall while the next byte is fetched
                  miso_oe_q <= 1'b1;
                  miso_q    <= tx_sh[7];
                  tx_sh     <= {tx_sh[6:0], 1'b0};
                  bit_cnt   <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(7)) begin
                     bit_cnt    <= '0;
                     addr       <= addr_inc;
                     mem_en_q   <= 1'b1;
                     mem_wr_q   <= 1'b0;
                     mem_addr_q <= addr_inc;
                  end
               end
               default: miso_oe_q <= 1'b0;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_sram_slave.sv
// Directed bench for spi_sram_slave: bit-banged SPI master, synchronous byte memory
// model and a strobe logger, with hand-computed expectations per scenario.
module tb_spi_sram_slave;
   localparam int unsigned HALF = 6;

   logic clk;
   logic rst_n;
   logic active;
   logic cmd_err;

   spi_sram_slave_if #(.ADDR_W(24)) bus ();

   spi_sram_slave #(.ADDR_W(24), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .active  (active),
      .cmd_err (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec  = 0;
   int errs = 0;

   logic [7:0]  mem [0:255];
   logic [23:0] wr_a [$];
   logic [7:0]  wr_d [$];
   logic [23:0] rd_a [$];
   int          oe_cnt  = 0;
   int          err_cnt = 0;
   int          consec  = 0;
   logic        en_prev = 1'b0;

   // synchronous memory: read data valid one clk after the strobe
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_wr) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
   end

   always @(negedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_wr) begin
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_wdata);
         end else begin
            rd_a.push_back(bus.mem_addr);
         end
         if (en_prev) consec++;
      end
      en_prev = bus.mem_en;
      if (bus.spi_miso_oe) oe_cnt++;
      if (cmd_err) err_cnt++;
   end

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         bus.spi_sclk = 1'b0;
         bus.spi_mosi = tx[i];
         repeat (HALF) @(negedge clk);
         bus.spi_sclk = 1'b1;
         rx[i] = bus.spi_miso;
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      spi_bits(tx, 8, rx);
   endtask

   task automatic cs_start();
      bus.spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_end();
      bus.spi_sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.spi_cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
      logic [7:0] rx;
      logic [23:0] av;
      av = a;
      spi_byte(cmd, rx);
      spi_byte(av[23:16], rx);
      spi_byte(av[15:8], rx);
      spi_byte(av[7:0], rx);
   endtask

   task automatic check_reset_outputs(input string tag);
      vec++;
      if ({bus.spi_miso, bus.spi_miso_oe, bus.mem_en, bus.mem_wr, active, cmd_err} !== 6'b0) begin
         errs++;
         $display("FAIL %s ctrl: got miso=%b oe=%b en=%b wr=%b act=%b err=%b, want all 0", tag,
                  bus.spi_miso, bus.spi_miso_oe, bus.mem_en, bus.mem_wr, active, cmd_err);
      end
      vec++;
      if (bus.mem_addr !== 24'h0) begin
         errs++;
         $display("FAIL %s mem_addr: got %h, want 000000", tag, bus.mem_addr);
      end
      vec++;
      if (bus.mem_wdata !== 8'h00) begin
         errs++;
         $display("FAIL %s mem_wdata: got %h, want 00", tag, bus.mem_wdata);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.spi_sclk = 1'b0;
      bus.spi_cs_n = 1'b1;
      bus.spi_mosi = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_writes(input string tag, input int w0, input int r0,
                               input logic [23:0] a0, input logic [7:0] d0,
                               input logic [23:0] a1, input logic [7:0] d1);
      vec++;
      if (wr_a.size() != w0 + 2 || rd_a.size() != r0) begin
         errs++;
         $display("FAIL %s strobes: got %0d writes %0d reads, want 2 writes 0 reads", tag,
                  wr_a.size() - w0, rd_a.size() - r0);
      end else begin
         vec++;
         if ({wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]} !== {a0, d0, a1, d1}) begin
            errs++;
            $display("FAIL %s data: got (%h,%h)(%h,%h), want (%h,%h)(%h,%h)", tag,
                     wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1], a0, d0, a1, d1);
         end
      end
   endtask

   task automatic test_write();
      logic [7:0] rx;
      int w0, r0;
      w0 = wr_a.size();
      r0 = rd_a.size();
      cs_start();
      vec++;
      if (active !== 1'b1) begin
         errs++;
         $display("FAIL write active: got %b, want 1", active);
      end
      send_hdr(8'h02, 24'h000010);
      spi_byte(8'hA5, rx);
      spi_byte(8'h5A, rx);
      cs_end();
      check_writes("write", w0, r0, 24'h10, 8'hA5, 24'h11, 8'h5A);
      vec++;
      if (active !== 1'b0) begin
         errs++;
         $display("FAIL write idle active: got %b, want 0", active);
      end
   endtask

   task automatic test_read();
      logic [7:0] rx0, rx1;
      int r0, o0, w0;
      r0 = rd_a.size();
      w0 = wr_a.size();
      o0 = oe_cnt;
      cs_start();
      send_hdr(8'h03, 24'h000010);
      vec++;
      if (oe_cnt != o0) begin
         errs++;
         $display("FAIL read oe_hdr: got %0d oe clks, want 0", oe_cnt - o0);
      end
      spi_byte(8'h00, rx0);
      spi_byte(8'h00, rx1);
      cs_end();
      vec++;
      if ({rx0, rx1} !== 16'hA55A) begin
         errs++;
         $display("FAIL read miso: got %h %h, want a5 5a", rx0, rx1);
      end
      vec++;
      if (rd_a.size() != r0 + 3 || wr_a.size() != w0) begin
         errs++;
         $display("FAIL read strobes: got %0d reads %0d writes, want 3 reads", rd_a.size() - r0,
                  wr_a.size() - w0);
      end else begin
         vec++;
         if ({rd_a[r0], rd_a[r0+1], rd_a[r0+2]} !== {24'h10, 24'h11, 24'h12}) begin
            errs++;
            $display("FAIL read addrs: got %h %h %h, want 10 11 12", rd_a[r0], rd_a[r0+1],
                     rd_a[r0+2]);
         end
      end
      vec++;
      if (oe_cnt == o0) begin
         errs++;
         $display("FAIL read oe_data: got 0 oe clks, want >0");
      end
   endtask

   task automatic test_fast_read();
      logic [7:0] rx;
      int r0;
      cs_start();
      send_hdr(8'h02, 24'h000020);
      spi_byte(8'h3C, rx);
      cs_end();
      r0 = rd_a.size();
      cs_start();
      send_hdr(8'h0B, 24'h000020);
      vec++;
      if (rd_a.size() != r0) begin
         errs++;
         $display("FAIL fast early_read: got %0d reads before dummy, want 0", rd_a.size() - r0);
      end
      spi_byte(8'h00, rx);
      vec++;
      if (rd_a.size() != r0 + 1) begin
         errs++;
         $display("FAIL fast dummy_read: got %0d reads, want 1", rd_a.size() - r0);
      end else begin
         vec++;
         if (rd_a[r0] !== 24'h20) begin
            errs++;
            $display("FAIL fast addr: got %h, want 000020", rd_a[r0]);
         end
      end
      spi_byte(8'h00, rx);
      cs_end();
      vec++;
      if (rx !== 8'h3C) begin
         errs++;
         $display("FAIL fast miso: got %h, want 3c", rx);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] rx;
      int w0, r0;
      w0 = wr_a.size();
      r0 = rd_a.size();
      cs_start();
      send_hdr(8'h02, 24'hFFFFFF);
      spi_byte(8'h11, rx);
      spi_byte(8'h22, rx);
      cs_end();
      check_writes("wrap", w0, r0, 24'hFFFFFF, 8'h11, 24'h000000, 8'h22);
   endtask

   task automatic test_bad_cmd();
      logic [7:0] rx;
      int e0, o0, r0, w0;
      e0 = err_cnt;
      o0 = oe_cnt;
      r0 = rd_a.size();
      w0 = wr_a.size();
      cs_start();
      spi_byte(8'h9F, rx);
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      cs_end();
      vec++;
      if (err_cnt != e0 + 1) begin
         errs++;
         $display("FAIL badcmd cmd_err: got %0d pulses, want 1", err_cnt - e0);
      end
      vec++;
      if (rd_a.size() != r0 || wr_a.size() != w0 || oe_cnt != o0) begin
         errs++;
         $display("FAIL badcmd quiet: got %0d reads %0d writes %0d oe clks, want 0 0 0",
                  rd_a.size() - r0, wr_a.size() - w0, oe_cnt - o0);
      end
      cs_start();
      send_hdr(8'h03, 24'h000010);
      spi_byte(8'h00, rx);
      cs_end();
      vec++;
      if (rx !== 8'hA5) begin
         errs++;
         $display("FAIL badcmd recover_miso: got %h, want a5", rx);
      end
      vec++;
      if (rd_a.size() != r0 + 2) begin
         errs++;
         $display("FAIL badcmd recover_reads: got %0d reads, want 2", rd_a.size() - r0);
      end else begin
         vec++;
         if (rd_a[r0] !== 24'h10) begin
            errs++;
            $display("FAIL badcmd recover_addr: got %h, want 000010", rd_a[r0]);
         end
      end
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      int w0;
      w0 = wr_a.size();
      cs_start();
      send_hdr(8'h02, 24'h000040);
      spi_bits(8'hFF, 5, rx);
      cs_end();
      vec++;
      if (wr_a.size() != w0) begin
         errs++;
         $display("FAIL abort partial_write: got %0d writes, want 0", wr_a.size() - w0);
      end
      cs_start();
      send_hdr(8'h03, 24'h000010);
      spi_bits(8'h00, 4, rx);
      vec++;
      if (bus.spi_miso_oe !== 1'b1 || active !== 1'b1) begin
         errs++;
         $display("FAIL abort midread: got oe=%b active=%b, want 1 1", bus.spi_miso_oe, active);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midread_reset");
      bus.spi_cs_n = 1'b1;
      bus.spi_sclk = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_fast_read();
      test_wrap();
      test_bad_cmd();
      test_abort();
      vec++;
      if (consec != 0) begin
         errs++;
         $display("FAIL strobe_spacing: got %0d back-to-back mem_en, want 0", consec);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
